reload_timer: RTL and testbench

//   Parametrised down-counting timer, successor to the single-shot 16-bit timer.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_prescaler.sv | 34 +++
 rtl/reload_timer.sv | 125 ++++++++++++
 tb/tb_reload_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared state encoding and mode constants for reload_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module   : timer_prescaler
// Purpose  : Tick divider for reload_timer; emits a tick every prescale+1
//            enabled clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] div_cnt;

  assign tick = enable && (div_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reload_timer.sv
// ============================================================================
// Module   : reload_timer
// Purpose  : Down-counting one-shot / auto-reload timer with pause and abort.
//            Define TIMER_PRESCALE_EN to add a prescale input and tick divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reload_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      cycles,
  input  logic                  periodic,
  input  logic                  pause,
  input  logic                  stop,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      count
);

  timer_state_t     state;
  timer_state_t     state_nxt;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             tick;
  logic             active;
  logic             do_load;
  logic             step;
  logic             expire;

  assign active  = (state != IDLE);
  assign do_load = load && (cycles != '0);
  assign step    = active && !pause && tick;
  // count==0 while active is unreachable, but treating it as expiry keeps underflow impossible
  assign expire  = step && ((count == WIDTH'(1)) || (count == '0));

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (!stop && do_load) begin
      prescale_q <= prescale;
    end
  end

  timer_prescaler #(
    .WIDTH (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (stop || do_load),
    .enable   (active && !pause),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (do_load) begin
      state_nxt = pause ? HOLD : RUN;
    end else if (active) begin
      if (pause) begin
        state_nxt = HOLD;
      end else if (expire && (mode == MODE_ONESHOT)) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      reload <= '0;
      mode   <= MODE_ONESHOT;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        count <= '0;
      end else if (do_load) begin
        count  <= cycles;
        reload <= cycles;
        mode   <= periodic;
      end else if (expire) begin
        done  <= 1'b1;
        count <= (mode == MODE_PERIODIC) ? reload : '0;
      end else if (step) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reload_timer.sv
// ============================================================================
// Module   : tb_reload_timer
// Purpose  : Directed self-checking bench for reload_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reload_timer;

  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  load = 1'b0;
  logic [WIDTH-1:0]      cycles = '0;
  logic                  periodic = 1'b0;
  logic                  pause = 1'b0;
  logic                  stop = 1'b0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      count;

  int vectors     = 0;
  int miscompares = 0;

  reload_timer #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .cycles   (cycles),
    .periodic (periodic),
    .pause    (pause),
    .stop     (stop),
`ifdef TIMER_PRESCALE_EN
    .prescale (prescale),
`endif
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic b, input logic d, input logic [WIDTH-1:0] c);
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".count"}, 32'(count), 32'(c));
  endtask

  task automatic do_load(input logic [WIDTH-1:0] n, input logic per);
    load = 1'b1; cycles = n; periodic = per;
    cyc();
    load = 1'b0; cycles = '0; periodic = 1'b0;
  endtask

  initial begin
    // 1: reset, one-shot 5
    cyc(); cyc();
    reset = 1'b0;
    expect_out("reset", 1'b0, 1'b0, 16'd0);
    do_load(16'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_out("oneshot5", 1'b1, 1'b0, WIDTH'(5 - i));
      cyc();
    end
    expect_out("oneshot5_end", 1'b0, 1'b1, 16'd0);
    cyc();
    expect_out("oneshot5_after", 1'b0, 1'b0, 16'd0);

    // 2: periodic 3, then stop
    do_load(16'd3, 1'b1);
    for (int i = 0; i < 9; i++) begin
      expect_out("periodic3", 1'b1, (i % 3 == 0) && (i > 0), WIDTH'(3 - (i % 3)));
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    expect_out("stop", 1'b0, 1'b0, 16'd0);
    cyc();
    expect_out("stop_after", 1'b0, 1'b0, 16'd0);

    // 3: one-shot 6 paused for 4 cycles at count 3
    do_load(16'd6, 1'b0);
    cyc(); cyc(); cyc();
    expect_out("pause_pre", 1'b1, 1'b0, 16'd3);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      expect_out("pause_hold", 1'b1, 1'b0, 16'd3);
    end
    pause = 1'b0;
    cyc();
    expect_out("pause_resume2", 1'b1, 1'b0, 16'd2);
    cyc();
    expect_out("pause_resume1", 1'b1, 1'b0, 16'd1);
    cyc();
    expect_out("pause_done", 1'b0, 1'b1, 16'd0);
    cyc();

    // 4: load 10, retrigger with 2 at count 7
    do_load(16'd10, 1'b0);
    cyc(); cyc(); cyc();
    expect_out("retrig_pre", 1'b1, 1'b0, 16'd7);
    do_load(16'd2, 1'b0);
    expect_out("retrig_2", 1'b1, 1'b0, 16'd2);
    cyc();
    expect_out("retrig_1", 1'b1, 1'b0, 16'd1);
    cyc();
    expect_out("retrig_done", 1'b0, 1'b1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("retrig_quiet", 1'b0, 1'b0, 16'd0);
    end

    // 5: zero load ignored, reset mid-run
    do_load(16'd0, 1'b1);
    expect_out("zero_load", 1'b0, 1'b0, 16'd0);
    do_load(16'd6, 1'b0);
    cyc(); cyc();
    expect_out("rst_pre", 1'b1, 1'b0, 16'd4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_out("rst_mid", 1'b0, 1'b0, 16'd0);

    // load on the expiry cycle wins with no done pulse
    do_load(16'd3, 1'b0);
    cyc(); cyc();
    expect_out("exp_load_pre", 1'b1, 1'b0, 16'd1);
    do_load(16'd4, 1'b0);
    expect_out("exp_load", 1'b1, 1'b0, 16'd4);

    // zero load while running changes nothing
    do_load(16'd0, 1'b1);
    expect_out("zero_load_run", 1'b1, 1'b0, 16'd3);

    // load with pause high goes straight to HOLD
    pause = 1'b1;
    do_load(16'd5, 1'b0);
    cyc();
    expect_out("load_paused", 1'b1, 1'b0, 16'd5);
    pause = 1'b0;
    cyc();
    expect_out("load_unpaused", 1'b1, 1'b0, 16'd4);

    // all-ones period
    do_load(16'hFFFF, 1'b1);
    expect_out("max_load", 1'b1, 1'b0, 16'hFFFF);
    cyc();
    expect_out("max_dec", 1'b1, 1'b0, 16'hFFFE);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    expect_out("max_stop", 1'b0, 1'b0, 16'd0);

`ifdef TIMER_PRESCALE_EN
    // 6: prescale 2, one-shot 4 -> 12 busy cycles
    prescale = 8'd2;
    do_load(16'd4, 1'b0);
    prescale = 8'd0;
    for (int i = 0; i < 12; i++) begin
      expect_out("presc", 1'b1, 1'b0, WIDTH'(4 - i / 3));
      cyc();
    end
    expect_out("presc_done", 1'b0, 1'b1, 16'd0);
    cyc();
    expect_out("presc_after", 1'b0, 1'b0, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
